// File: rtl/send_row_pkg.sv
// Shared constants and FSM state encoding for the send_row row serializer.
package send_row_pkg;

    localparam int ROW_W_DEF  = 480;
    localparam int WORD_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        REQ   = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/send_row.sv
// Row serializer: captures one ROW_W row and streams it LSB word first over valid/ack.
// Optional macro SEND_ROW_PARITY_EN adds a registered even-parity output per word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ready; captures row and presents word 0 next cycle
// SHIFT | data_valid high, advancing one word per acked cycle
// REQ   | one-cycle send pulse asking the loader for the next row
// GAP   | one idle cycle so the loader can update row/ready
module send_row
    import send_row_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int WORD_W = WORD_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROW_W-1:0]  row,
    input  logic              ready,
    output logic              send,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              busy
`ifdef SEND_ROW_PARITY_EN
    ,
    output logic              data_parity
`endif
);

    localparam int NUM_WORDS = ROW_W / WORD_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ROW_W-1:0]    r_shift;
    logic [ROW_W-1:0]    w_shift_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_parity;
    logic                w_capture;
    logic                w_advance;
    logic                w_last_ack;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_last_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (ready) begin
                    w_capture    = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (data_ack) begin
                    if (r_cnt == LAST_IDX) begin
                        w_last_ack   = 1'b1;
                        w_state_next = REQ;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            REQ:     w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The low word of the shift register is always the word on display, so the
    // next word is simply the low slice of the register shifted down once.
    assign w_shift_next = r_shift >> WORD_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity     <= 1'b0;
        end else if (w_capture) begin
            r_shift      <= row;
            r_cnt        <= '0;
            r_data_out   <= row[WORD_W-1:0];
            r_data_valid <= 1'b1;
            r_parity     <= ^row[WORD_W-1:0];
        end else if (w_advance) begin
            r_shift      <= w_shift_next;
            r_cnt        <= r_cnt + CNT_W'(1);
            r_data_out   <= w_shift_next[WORD_W-1:0];
            r_data_valid <= 1'b1;
            r_parity     <= ^w_shift_next[WORD_W-1:0];
        end else if (w_last_ack) begin
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity     <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = (r_state == SHIFT);
    assign send       = (r_state == REQ);

`ifdef SEND_ROW_PARITY_EN
    assign data_parity = r_parity;
`else
    logic w_parity_unused;
    assign w_parity_unused = r_parity;
`endif

endmodule

// File: tb/tb_send_row.sv
// Directed self-checking bench for send_row; parity checks build only with SEND_ROW_PARITY_EN.
module tb_send_row;

    logic         clk;
    logic         rst;
    logic [479:0] row;
    logic         ready;
    logic         send;
    logic [15:0]  data_out;
    logic         data_valid;
    logic         data_ack;
    logic         busy;
`ifdef SEND_ROW_PARITY_EN
    logic         data_parity;
`endif

    int checks   = 0;
    int failures = 0;

    send_row dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .ready      (ready),
        .send       (send),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy)
`ifdef SEND_ROW_PARITY_EN
        ,
        .data_parity(data_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [479:0] make_row(input logic [15:0] base);
        logic [479:0] r;
        r = '0;
        for (int k = 0; k < 30; k++) r[16*k +: 16] = base + 16'(k);
        return r;
    endfunction

    // Bounded wait for the send pulse with ack held high; leaves the DUT back in IDLE.
    task automatic wait_send(output bit seen);
        seen     = 1'b0;
        data_ack = 1'b1;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (send === 1'b1) seen = 1'b1;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; data_ack = 1'b0; row = '0;
        step(); step();
        checks++;
        if ({send, data_valid, busy} !== 3'b000 || data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs: send=%b valid=%b busy=%b data=%h, required 0 0 0 0000",
                     send, data_valid, busy, data_out);
        end
`ifdef SEND_ROW_PARITY_EN
        checks++;
        if (data_parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity: got %b required 0", data_parity);
        end
`endif
        rst = 1'b0;
        data_ack = 1'b1;
        step();
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_ignored: valid=%b busy=%b required 0 0", data_valid, busy);
        end
    endtask

    task automatic test_word_order();
        int sends;
        sends = 0;
        data_ack = 1'b1;
        row = make_row(16'h0100);
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== 16'h0100 + 16'(k) || busy !== 1'b1) begin
                failures++;
                $display("FAIL word_order[%0d]: valid=%b busy=%b data=%h required 1 1 %h",
                         k, data_valid, busy, data_out, 16'h0100 + 16'(k));
            end
            if (send === 1'b1) sends++;
            step();
        end
        checks++;
        if (send !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0 || sends != 0) begin
            failures++;
            $display("FAIL word_order_send: send=%b valid=%b busy=%b early_sends=%0d required 1 0 0 0",
                     send, data_valid, busy, sends);
        end
        step();
        checks++;
        if (send !== 1'b0) begin
            failures++;
            $display("FAIL word_order_send_width: send=%b in GAP required 0", send);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit seen;
        data_ack = 1'b1;
        row = make_row(16'h0100);
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int k = 0; k < 7; k++) step();
        data_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== 16'h0107) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h required 1 0107",
                         c, data_valid, data_out);
            end
            step();
        end
        checks++;
        if (data_out !== 16'h0107) begin
            failures++;
            $display("FAIL backpressure_no_ack: data=%h required 0107", data_out);
        end
        data_ack = 1'b1;
        step();
        checks++;
        if (data_out !== 16'h0108 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_resume: valid=%b data=%h required 1 0108", data_valid, data_out);
        end
        wait_send(seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_send: send seen=%b required 1", seen);
        end
    endtask

    task automatic test_back_to_back();
        int sends;
        sends = 0;
        data_ack = 1'b1;
        row = make_row(16'h0200);
        ready = 1'b1;
        step();
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (data_out !== 16'h0200 + 16'(k) || data_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_row1[%0d]: valid=%b data=%h required 1 %h",
                         k, data_valid, data_out, 16'h0200 + 16'(k));
            end
            if (send === 1'b1) sends++;
            step();
        end
        if (send === 1'b1) sends++;
        row = '1;
        step();
        if (send === 1'b1) sends++;
        step();
        if (send === 1'b1) sends++;
        step();
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (data_out !== 16'hFFFF || data_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_row2[%0d]: valid=%b data=%h required 1 ffff", k, data_valid, data_out);
            end
            if (send === 1'b1) sends++;
            step();
        end
        ready = 1'b0;
        if (send === 1'b1) sends++;
        checks++;
        if (sends != 2) begin
            failures++;
            $display("FAIL b2b_send_count: got %0d pulses required 2", sends);
        end
        step();
        step();
    endtask

    task automatic test_ignored_inputs();
        data_ack = 1'b1;
        row = make_row(16'h0300);
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (data_out !== 16'h0300 + 16'(k) || data_valid !== 1'b1) begin
                failures++;
                $display("FAIL ignored_inputs[%0d]: valid=%b data=%h required 1 %h",
                         k, data_valid, data_out, 16'h0300 + 16'(k));
            end
            ready = k[0];
            if (k == 3) row = make_row(16'h0A00);
            step();
        end
        ready = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_row();
        bit seen;
        data_ack = 1'b1;
        row = make_row(16'h0500);
        ready = 1'b1;
        step();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (data_out !== 16'h0505) begin
            failures++;
            $display("FAIL reset_mid_pre: data=%h required 0505", data_out);
        end
        rst = 1'b1;
        ready = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({send, data_valid, busy} !== 3'b000 || data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_outputs: send=%b valid=%b busy=%b data=%h required 0 0 0 0000",
                     send, data_valid, busy, data_out);
        end
        step();
        ready = 1'b0;
        checks++;
        if (data_out !== 16'h0500 || data_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_recapture: valid=%b busy=%b data=%h required 1 1 0500",
                     data_valid, busy, data_out);
        end
        wait_send(seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_send: send seen=%b required 1", seen);
        end
    endtask

`ifdef SEND_ROW_PARITY_EN
    task automatic test_parity();
        bit seen;
        data_ack = 1'b1;
        row = '0;
        row[15:0]  = 16'h0003;
        row[31:16] = 16'h0007;
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if (data_out !== 16'h0003 || data_parity !== 1'b0) begin
            failures++;
            $display("FAIL parity_word0: data=%h parity=%b required 0003 0", data_out, data_parity);
        end
        step();
        checks++;
        if (data_out !== 16'h0007 || data_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_word1: data=%h parity=%b required 0007 1", data_out, data_parity);
        end
        wait_send(seen);
        checks++;
        if (data_parity !== 1'b0 || seen !== 1'b1) begin
            failures++;
            $display("FAIL parity_idle: parity=%b send_seen=%b required 0 1", data_parity, seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word_order();
        test_backpressure();
        test_back_to_back();
        test_ignored_inputs();
        test_reset_mid_row();
`ifdef SEND_ROW_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/send_row.md
Name: send_row

Overview:
- Row serializer between the CPU-side row loader and the DCNN image input.
- Captures one 480-bit image row when the loader flags it ready.
- Streams the row as 30 16-bit words over a valid/ack interface.
- Pulses `send` to request the next row from the loader.

Parameters:
- ROW_W, 480, width of one captured row in bits.
- WORD_W, 16, width of one output word; ROW_W must be an integer multiple of WORD_W.
- NUM_WORDS, ROW_W/WORD_W (30), derived; not overridable.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- row  input  ROW_W  row data from the loader; sampled only at capture.
- ready  input  1  loader flag: `row` holds a valid unconsumed row.
- send  output  1  one-cycle pulse: row fully transmitted, loader may advance.
- data_out  output  WORD_W  current output word.
- data_valid  output  1  data_out is valid.
- data_ack  input  1  consumer accepts data_out this cycle when data_valid=1.
- busy  output  1  high from capture through the last word accepted.

Behaviour:
- Reset: rst=1 at a clock edge forces the following, overriding any in-flight row (the partial row is discarded):
  - state=IDLE, word counter=0, shift register=0;
  - send=0, data_valid=0, data_out=0, busy=0.
- States: IDLE, SHIFT, REQ, GAP.
- IDLE:
  - If ready=1 at an edge, capture `row` into the internal shift register, clear the counter, set busy=1 and go to SHIFT.
  - Otherwise stay in IDLE; outputs stay 0.
- SHIFT:
  - data_valid=1 and data_out = word k = captured[WORD_W*k+WORD_W-1 : WORD_W*k], where k = counter. Word 0 is the LSBs (LSB-first order).
  - data_out and data_valid are registered: word 0 appears the cycle after capture.
  - On an edge with data_ack=1, advance to word k+1 on the next cycle.
  - While data_ack=0, data_out and data_valid hold unchanged; there is no timeout.
  - When word NUM_WORDS-1 is acked, deassert data_valid and busy next cycle and go to REQ.
- REQ:
  - send=1 for exactly one cycle, then go to GAP.
- GAP:
  - One idle cycle so the loader can update `row`/`ready`, then go to IDLE.
  - Rows are back-to-back with ready held high. Minimum per-row overhead = 1 capture + 30 word cycles + REQ + GAP.
- Changes to `ready`/`row` outside IDLE are ignored; row content is frozen at capture.
- `data_ack` while data_valid=0 is ignored.
- Counter is ceil(log2(NUM_WORDS)) bits wide and never exceeds NUM_WORDS-1.

Optional Feature:
- Macro: SEND_ROW_PARITY_EN.
- Defined: adds output port `data_parity` (1 bit), registered alongside data_out. It equals the even parity (XOR reduction) of data_out. It is 0 whenever data_valid=0 and 0 after reset.
- Undefined: the port does not exist; all other behaviour is identical.

Decomposition:
- Package send_row_pkg holds:
  - constants ROW_W_DEF=480, WORD_W_DEF=16;
  - the state enum typedef (IDLE, SHIFT, REQ, GAP).
- No sub-module; the FSM, counter and shift/select datapath live in send_row.

Test Plan:
- Reset mid-row:
  - Stimulus: capture a row, ack 5 words, assert rst for 1 cycle.
  - Required: data_valid=0, busy=0, send=0 the next cycle; with ready=1 a fresh capture follows and word 0 is re-sent.
- Word order:
  - Stimulus: row = {30 words, word k = 16'h0100+k}, data_ack tied 1.
  - Required: data_out sequence 0100,0101,…,011D on 30 consecutive cycles; send pulses once, 1 cycle later.
- Backpressure:
  - Stimulus: data_ack=0 for 4 cycles during word 7.
  - Required: data_out stays 0x0107 with data_valid=1 for all 4 cycles; word 8 follows only after an ack.
- Back-to-back rows:
  - Stimulus: ready held 1; row changed to all-ones after the send pulse.
  - Required: second row streams 30 × 0xFFFF; exactly one send pulse per row; no word duplicated or lost.
- Ignored inputs:
  - Stimulus: change `row` and toggle ready during SHIFT.
  - Required: output words still match the row captured at the start.
- Parity (SEND_ROW_PARITY_EN defined):
  - Stimulus: word 0x0003, then word 0x0007.
  - Required: data_parity=0, then 1.
